// File: rtl/cpu_debug_pkg.sv
// Shared state encoding and defaults for the CPU run-control / debug sequencer.
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        DBG_IDLE  = 2'd0,
        DBG_STEP  = 2'd1,
        DBG_RUN   = 2'd2,
        DBG_BREAK = 2'd3
    } dbg_state_t;

    localparam int ADDR_STEP_DEFAULT = 4;

endpackage

// File: rtl/edge_pulse.sv
// One-cycle pulse on a rising edge of d. The history flop resets to 1 so that
// a button already held when reset is released never produces a pulse.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control sequencer: CPU clock-enable (pause/step/run/breakpoint) and debug view address.
// Optional DBG_CYCLE_CNT_EN adds cycle_cnt, a count of cycles with cpu_en high.
module cpu_debug_ctrl
    import cpu_debug_pkg::*;
#(
    parameter int VIEW_AW   = 10,
    parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic        inc,
    input  logic        dec,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic [31:0] m_rf_addr,
    output logic [1:0]  dbg_state,
    output logic        halted
`ifdef DBG_CYCLE_CNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);

    localparam logic [VIEW_AW-1:0] STEP_V = VIEW_AW'(ADDR_STEP);

    logic step_pulse;
    logic inc_pulse;
    logic dec_pulse;
    logic bp_hit;
    logic run_en;

    dbg_state_t         state;
    dbg_state_t         state_nxt;
    logic [VIEW_AW-1:0] view_addr;

    edge_pulse u_step_edge (.clk(clk), .rst(rst), .d(step), .pulse(step_pulse));
    edge_pulse u_inc_edge  (.clk(clk), .rst(rst), .d(inc),  .pulse(inc_pulse));
    edge_pulse u_dec_edge  (.clk(clk), .rst(rst), .d(dec),  .pulse(dec_pulse));

    assign bp_hit = bp_en & (pc == bp_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= DBG_IDLE;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == DBG_BREAK);
        end
    end

    always_comb begin
        state_nxt = state;
        run_en    = 1'b0;
        unique case (state)
            DBG_IDLE: begin
                if (run) begin
                    state_nxt = DBG_RUN;
                end else if (step_pulse) begin
                    state_nxt = DBG_STEP;
                end
            end
            DBG_STEP: begin
                run_en    = 1'b1;
                state_nxt = run ? DBG_RUN : DBG_IDLE;
            end
            DBG_RUN: begin
                // Stall combinationally so the instruction at bp_addr is not advanced past.
                run_en = ~bp_hit;
                if (!run) begin
                    state_nxt = DBG_IDLE;
                end else if (bp_hit) begin
                    state_nxt = DBG_BREAK;
                end
            end
            DBG_BREAK: begin
                if (!run) begin
                    state_nxt = DBG_IDLE;
                end else if (step_pulse) begin
                    state_nxt = DBG_STEP;
                end
            end
            default: state_nxt = DBG_IDLE;
        endcase
    end

    assign cpu_en    = rst & run_en;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            view_addr <= '0;
        end else if (inc_pulse && !dec_pulse) begin
            view_addr <= view_addr + STEP_V;
        end else if (dec_pulse && !inc_pulse) begin
            view_addr <= view_addr - STEP_V;
        end
    end

    assign m_rf_addr = 32'(view_addr);

`ifdef DBG_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl: reset hold, stepping, breakpoint, run priority, address wrap.
module tb_cpu_debug_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic        inc;
    logic        dec;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic [31:0] m_rf_addr;
    logic [1:0]  dbg_state;
    logic        halted;
`ifdef DBG_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cpu_debug_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .inc       (inc),
        .dec       (dec),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .m_rf_addr (m_rf_addr),
        .dbg_state (dbg_state),
        .halted    (halted)
`ifdef DBG_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; step = 1'b1; inc = 1'b0; dec = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;

        // Reset hold with step held high
        repeat (3) cyc();
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state",  32'(dbg_state), 32'd0);
        check("rst_addr",   m_rf_addr, 32'h0);
        rst = 1'b1;
        #1;
        check("rel_cpu_en", 32'(cpu_en), 32'd0);
        cyc();
        check("rel_state1", 32'(dbg_state), 32'd0);
        check("rel_cpu_en1", 32'(cpu_en), 32'd0);
        cyc();
        check("rel_state2", 32'(dbg_state), 32'd0);
        step = 1'b0;
        cyc();

        // Single step, twice
        for (int i = 0; i < 2; i++) begin
            step = 1'b1;
            #1;
            check("step_pre_en", 32'(cpu_en), 32'd0);
            cyc();
            check("step_state", 32'(dbg_state), 32'd1);
            check("step_en", 32'(cpu_en), 32'd1);
            cyc();
            check("step_back_idle", 32'(dbg_state), 32'd0);
            check("step_en_off", 32'(cpu_en), 32'd0);
            step = 1'b0;
            cyc();
            check("step_idle_en", 32'(cpu_en), 32'd0);
        end

        // Breakpoint at 0x10 while running
        bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h0; run = 1'b1;
        #1;
        check("bp_idle_en", 32'(cpu_en), 32'd0);
        cyc();
        check("bp_run_state", 32'(dbg_state), 32'd2);
        for (int a = 0; a < 16; a += 4) begin
            pc = 32'(a);
            #1;
            check("bp_run_en", 32'(cpu_en), 32'd1);
            cyc();
        end
        pc = 32'h10;
        #1;
        check("bp_hit_en", 32'(cpu_en), 32'd0);
        check("bp_hit_halted", 32'(halted), 32'd0);
        cyc();
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_state", 32'(dbg_state), 32'd3);
        check("bp_en_off", 32'(cpu_en), 32'd0);
        cyc();
        check("bp_hold", 32'(dbg_state), 32'd3);
        step = 1'b1;
        #1;
        check("bp_pre_step_en", 32'(cpu_en), 32'd0);
        cyc();
        check("bp_step_state", 32'(dbg_state), 32'd1);
        check("bp_step_en", 32'(cpu_en), 32'd1);
        check("bp_step_halted", 32'(halted), 32'd0);
        step = 1'b0;
        pc = 32'h14;
        cyc();
        check("bp_resume_state", 32'(dbg_state), 32'd2);
        check("bp_resume_en", 32'(cpu_en), 32'd1);

        // run=0 wins over a breakpoint hit in RUN
        pc = 32'h10; run = 1'b0;
        #1;
        check("prio_en", 32'(cpu_en), 32'd0);
        cyc();
        check("prio_state", 32'(dbg_state), 32'd0);
        check("prio_halted", 32'(halted), 32'd0);

        // BREAK released by run=0
        run = 1'b1;
        cyc();
        cyc();
        check("brk2_state", 32'(dbg_state), 32'd3);
        run = 1'b0;
        cyc();
        check("brk2_idle", 32'(dbg_state), 32'd0);
        check("brk2_halted", 32'(halted), 32'd0);
        bp_en = 1'b0;

        // Address window wrap
        dec = 1'b1;
        cyc();
        check("addr_dec_wrap", m_rf_addr, 32'h3FC);
        dec = 1'b0;
        cyc();
        inc = 1'b1;
        cyc();
        check("addr_inc_wrap", m_rf_addr, 32'h000);
        inc = 1'b0;
        cyc();
        inc = 1'b1;
        cyc();
        check("addr_inc", m_rf_addr, 32'h004);
        inc = 1'b0;
        cyc();
        inc = 1'b1; dec = 1'b1;
        cyc();
        check("addr_both", m_rf_addr, 32'h004);
        cyc();
        check("addr_held", m_rf_addr, 32'h004);
        inc = 1'b0;
        dec = 1'b0;
        cyc();

`ifdef DBG_CYCLE_CNT_EN
        rst = 1'b0;
        cyc();
        check("cnt_rst", cycle_cnt, 32'd0);
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            step = 1'b1;
            cyc();
            cyc();
            step = 1'b0;
            cyc();
        end
        check("cnt_steps", cycle_cnt, 32'd5);
        run = 1'b1;
        cyc();
        repeat (9) cyc();
        run = 1'b0;
        cyc();
        check("cnt_total", cycle_cnt, 32'd15);
        rst = 1'b0;
        cyc();
        check("cnt_rst2", cycle_cnt, 32'd0);
        rst = 1'b1;
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
